// File: rtl/rsa_div_pkg.sv
// Shared constants and types for the RSA modular-reduction divider scheduler.
package rsa_div_pkg;

  localparam int DATA_LENGTH = 1024;
  localparam int DATA_W      = DATA_LENGTH + 1;
  localparam int DIV_LAT     = DATA_LENGTH + 2;
  localparam int TIMEOUT     = 1040;
  localparam int CNT_W       = 11;

  typedef enum logic [2:0] {
    SYNC,
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_e;

  localparam logic [DATA_W-1:0] ALL_ZERO = '0;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the rotating pointer,
// which advances past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  int               cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_vld && req[cand]) begin
        grant_vld   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && grant_vld)
      ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/div_sched.sv
// Shares one non-restoring divider among NUM_REQ requesters: arbitrate, launch,
// wait for done or timeout, and hand quotient/remainder back to the winner.
module div_sched
  import rsa_div_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = rsa_div_pkg::DATA_W,
  parameter  int DIV_LAT = rsa_div_pkg::DIV_LAT,
  parameter  int TIMEOUT = rsa_div_pkg::TIMEOUT,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]        resp_valid,
  input  logic [NUM_REQ-1:0]        resp_ready,
  output logic [DATA_W-1:0]         resp_quot,
  output logic [DATA_W-1:0]         resp_rem,
  output logic                      resp_err,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_quot,
  input  logic [DATA_W-1:0]         div_rem
);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [DATA_W-1:0]  quot_q, quot_d, rem_q, rem_d;
  logic               err_q, err_d;
  logic               to_q, to_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;
  logic [DATA_W-1:0]  sel_dividend, sel_divisor;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  assign sel_dividend = req_dividend[int'(arb_idx)*DATA_W +: DATA_W];
  assign sel_divisor  = req_divisor[int'(arb_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      cnt_q   <= '0;
      gid_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    to_d    = to_q;
    unique case (state_q)
      // The divider has no reset, so sit out a full divide before trusting it.
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (arb_vld) begin
          gid_d = arb_idx;
          opa_d = sel_dividend;
          opb_d = sel_divisor;
          to_d  = 1'b0;
          if (sel_divisor == '0) begin
            quot_d  = '1;
            rem_d   = sel_dividend;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (div_done) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready[gid_q]) begin
          state_d = to_q ? SYNC : IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;
    if (state_q == IDLE)   req_ready         = arb_grant;
    if (state_q == RESP)   resp_valid[gid_q] = 1'b1;
    if (state_q == LAUNCH) div_start         = 1'b1;
  end

  assign resp_quot    = quot_q;
  assign resp_rem     = rem_q;
  assign resp_err     = err_q;
  assign div_dividend = opa_q;
  assign div_divisor  = opb_q;

  // Late done pulses are expected while flushing (SYNC) or after an abort.
  a_done_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    !(div_done && !to_q && (state_q inside {IDLE, LAUNCH, RESP})));

endmodule
